// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO in front of it.
// Bytes are queued on valid && ready and sent as 8N1 frames, LSB first.
// A frame that ends with more bytes queued runs straight into the next start bit.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          valid,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] ClkLast = CntW'(ClksPerBit - 1);
  localparam logic [PtrW:0]   Full    = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            push, pop;

  state_e          state_q, state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  // Ready comes only from the registered count, so it never depends on valid.
  assign ready      = (count_q != Full);
  assign push       = valid && ready;
  assign fifo_count = count_q;
  assign tx         = tx_q;

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // FIFO occupancy: push and pop on the same edge cancel.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count; power-of-two depth makes pointer wrap implicit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // FSM and datapath state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // Next-state logic; tx is computed one clock ahead so the line is registered.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d   = mem_q[rd_ptr_q];
          tx_d      = 1'b0;
          clk_cnt_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (clk_cnt_q == ClkLast) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
          state_d   = StData;
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (clk_cnt_q == ClkLast) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (clk_cnt_q == ClkLast) begin
          clk_cnt_d = '0;
          if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: busy outside IDLE; pop when idle or at the last stop-bit clock with data queued.
  always_comb begin
    busy = (state_q != StIdle);
    pop  = (count_q != '0) &&
           ((state_q == StIdle) || ((state_q == StStop) && (clk_cnt_q == ClkLast)));
  end

endmodule
